// File: rtl/branch_pkg.sv
// Shared encodings for the ID-stage branch resolution logic: control-flow op codes,
// resolver FSM states and operand/link classification helpers.
package branch_pkg;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLEZ = 4'd3;
    localparam logic [3:0] BR_BGTZ = 4'd4;
    localparam logic [3:0] BR_BLTZ = 4'd5;
    localparam logic [3:0] BR_BGEZ = 4'd6;
    localparam logic [3:0] BR_J    = 4'd7;
    localparam logic [3:0] BR_JAL  = 4'd8;
    localparam logic [3:0] BR_JR   = 4'd9;
    localparam logic [3:0] BR_JALR = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HELD = 2'd2
    } br_state_t;

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op >= BR_BEQ) && (op <= BR_JALR);
    endfunction

    function automatic logic needs_rs(input logic [3:0] op);
        logic r;
        case (op)
            BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ,
            BR_BLTZ, BR_BGEZ, BR_JR, BR_JALR: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic needs_rt(input logic [3:0] op);
        return (op == BR_BEQ) || (op == BR_BNE);
    endfunction

    function automatic logic is_link(input logic [3:0] op);
        return (op == BR_JAL) || (op == BR_JALR);
    endfunction

endpackage

// File: rtl/br_cond.sv
// Combinational branch condition evaluator on forwarded operands (signed compares);
// jumps are unconditionally taken, NONE and unknown ops never are.
module br_cond
    import branch_pkg::*;
(
    input  logic [3:0]  i_br_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic        o_taken
);

    // Select the condition for the decoded op
    always_comb begin
        o_taken = 1'b0;
        case (i_br_op)
            BR_BEQ:  o_taken = (i_rs == i_rt);
            BR_BNE:  o_taken = (i_rs != i_rt);
            BR_BLEZ: o_taken = ($signed(i_rs) <= 32'sd0);
            BR_BGTZ: o_taken = ($signed(i_rs) >  32'sd0);
            BR_BLTZ: o_taken = ($signed(i_rs) <  32'sd0);
            BR_BGEZ: o_taken = ($signed(i_rs) >= 32'sd0);
            BR_J, BR_JAL, BR_JR, BR_JALR: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch/jump resolver: stalls on unready operands, issues one PC redirect per
// control-flow instruction even while ID is held, and keeps saturating statistics.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [3:0]       br_op,
    input  logic [31:0]      pc_id,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_index,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             ex_stall,
    output logic             stall_id,
    output logic             redirect,
    output logic [31:0]      target,
    output logic             link,
    output logic [31:0]      link_addr,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             timeout_err
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);

    br_state_t        r_state;
    br_state_t        w_state_nxt;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [WC_W-1:0]  w_wait_nxt;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic             r_timeout_err;

    logic [3:0]       w_op;
    logic             w_ctrl;
    logic             w_ops_ok;
    logic             w_taken;
    logic             w_resolve;
    logic             w_stall;
    logic             w_set_err;
    logic [31:0]      w_pc4;
    logic [31:0]      w_br_tgt;
    logic [31:0]      w_j_tgt;

    // Unknown encodings collapse to NONE so they never stall or count
    assign w_op     = is_ctrl(br_op) ? br_op : BR_NONE;
    assign w_ctrl   = id_valid & is_ctrl(br_op);
    assign w_ops_ok = (~needs_rs(w_op) | rs_ready) & (~needs_rt(w_op) | rt_ready);

    br_cond u_br_cond (
        .i_br_op (w_op),
        .i_rs    (rs_data),
        .i_rt    (rt_data),
        .o_taken (w_taken)
    );

    assign w_pc4    = pc_id + 32'd4;
    assign w_br_tgt = w_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign w_j_tgt  = {w_pc4[31:28], instr_index, 2'b00};

    // Redirect address mux by control-flow class
    always_comb begin
        target = w_br_tgt;
        case (w_op)
            BR_J, BR_JAL:   target = w_j_tgt;
            BR_JR, BR_JALR: target = rs_data;
            default:        target = w_br_tgt;
        endcase
    end

    // Resolver next-state and same-cycle control decode
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_resolve   = 1'b0;
        w_stall     = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_IDLE, ST_WAIT: begin
                if (!w_ctrl) begin
                    w_state_nxt = ST_IDLE;
                    w_wait_nxt  = '0;
                end else if (!w_ops_ok) begin
                    w_stall     = 1'b1;
                    w_state_nxt = ST_WAIT;
                    if (r_state == ST_IDLE) begin
                        w_wait_nxt = WC_W'(1);
                    end else begin
                        w_set_err  = (r_wait_cnt == WC_W'(MAX_WAIT - 1));
                        w_wait_nxt = (r_wait_cnt == WC_W'(MAX_WAIT)) ? r_wait_cnt
                                                                     : r_wait_cnt + WC_W'(1);
                    end
                end else begin
                    w_resolve   = 1'b1;
                    w_wait_nxt  = '0;
                    w_state_nxt = ex_stall ? ST_HELD : ST_IDLE;
                end
            end
            ST_HELD: begin
                w_wait_nxt  = '0;
                w_state_nxt = (!id_valid || !ex_stall) ? ST_IDLE : ST_HELD;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_wait_nxt  = '0;
            end
        endcase
    end

    assign stall_id  = w_stall & ~reset;
    assign redirect  = w_resolve & w_taken & ~reset;
    assign link      = w_resolve & is_link(w_op) & ~reset;
    assign link_addr = pc_id + 32'd8;

    // State, wait counter, saturating statistics and sticky timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_br_cnt      <= '0;
            r_taken_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_resolve && (r_br_cnt != {CNT_W{1'b1}})) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_resolve && w_taken && (r_taken_cnt != {CNT_W{1'b1}})) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
            if (w_set_err) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign br_cnt      = r_br_cnt;
    assign taken_cnt   = r_taken_cnt;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus randomized
// instruction streams compared against an instruction-level reference model.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [3:0]  br_op;
    logic [31:0] pc_id;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data, rt_data;
    logic        rs_ready, rt_ready, ex_stall;
    logic        stall_id, redirect, link, timeout_err;
    logic [31:0] target, link_addr;
    logic [15:0] br_cnt, taken_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.CNT_W(16), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .br_op(br_op), .pc_id(pc_id),
        .imm16(imm16), .instr_index(instr_index), .rs_data(rs_data), .rt_data(rt_data),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .ex_stall(ex_stall),
        .stall_id(stall_id), .redirect(redirect), .target(target), .link(link),
        .link_addr(link_addr), .br_cnt(br_cnt), .taken_cnt(taken_cnt),
        .timeout_err(timeout_err)
    );

    // ---------------- reference model (instruction-level rules) ----------------
    function automatic logic m_is_ctrl(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd10);
    endfunction
    function automatic logic m_needs_rs(input logic [3:0] op);
        return ((op >= 4'd1) && (op <= 4'd6)) || (op == 4'd9) || (op == 4'd10);
    endfunction
    function automatic logic m_needs_rt(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd2);
    endfunction
    function automatic logic m_taken(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int s;
        s = $signed(rs);
        if (op == 4'd1) return rs == rt;
        if (op == 4'd2) return rs != rt;
        if (op == 4'd3) return s <= 0;
        if (op == 4'd4) return s > 0;
        if (op == 4'd5) return s < 0;
        if (op == 4'd6) return s >= 0;
        return (op >= 4'd7) && (op <= 4'd10);
    endfunction
    function automatic logic [31:0] m_target(input logic [3:0] op, input logic [31:0] pc,
                                             input logic [15:0] imm, input logic [25:0] idx,
                                             input logic [31:0] rs);
        logic [31:0] pc4;
        int sext;
        pc4  = pc + 32'd4;
        sext = $signed(imm);
        if (op == 4'd7 || op == 4'd8) return (pc4 & 32'hF000_0000) | (32'(idx) * 32'd4);
        if (op == 4'd9 || op == 4'd10) return rs;
        return pc4 + 32'(sext * 4);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] pc,
                         input logic [15:0] imm, input logic [25:0] idx,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic rsr, input logic rtr, input logic exs);
        id_valid = v; br_op = op; pc_id = pc; imm16 = imm; instr_index = idx;
        rs_data = rs; rt_data = rt; rs_ready = rsr; rt_ready = rtr; ex_stall = exs;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 4'd1, 32'h3000, 16'd4, 26'd0, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redirect got=%0b exp=0", redirect); end
        n_tests++; if (link !== 1'b0) begin n_fail++; $display("FAIL rst_link got=%0b exp=0", link); end
        tick();
        drive(1'b1, 4'd2, 32'h3000, 16'd4, 26'd0, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
        #4;
        n_tests++; if (stall_id !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%0b exp=0", stall_id); end
        tick();
        reset = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (br_cnt !== 16'd0 || taken_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", br_cnt, taken_cnt); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0b exp=0", timeout_err); end
        tick();
    endtask

    task automatic test_beq();
        apply_reset();
        drive(1'b1, 4'd1, 32'h3000, 16'h0004, 26'd0, 32'h5, 32'h5, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (redirect !== 1'b1 || stall_id !== 1'b0) begin n_fail++; $display("FAIL beq_redirect got=%0b stall=%0b exp=1/0", redirect, stall_id); end
        n_tests++; if (target !== 32'h3014) begin n_fail++; $display("FAIL beq_target got=%h exp=00003014", target); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (br_cnt !== 16'd1 || taken_cnt !== 16'd1) begin n_fail++; $display("FAIL beq_cnt got=%0d/%0d exp=1/1", br_cnt, taken_cnt); end
        tick();
    endtask

    task automatic test_bne_wait();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'd2, 32'h1000, 16'h0010, 26'd0, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
            #4;
            n_tests++; if (stall_id !== 1'b1 || redirect !== 1'b0) begin n_fail++; $display("FAIL bne_wait%0d stall=%0b redirect=%0b exp=1/0", c, stall_id, redirect); end
            tick();
        end
        drive(1'b1, 4'd2, 32'h1000, 16'h0010, 26'd0, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (stall_id !== 1'b0 || redirect !== 1'b1) begin n_fail++; $display("FAIL bne_resolve stall=%0b redirect=%0b exp=0/1", stall_id, redirect); end
        n_tests++; if (target !== 32'h1044) begin n_fail++; $display("FAIL bne_target got=%h exp=00001044", target); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (timeout_err !== 1'b0 || br_cnt !== 16'd1) begin n_fail++; $display("FAIL bne_post err=%0b br_cnt=%0d exp=0/1", timeout_err, br_cnt); end
        tick();
    endtask

    task automatic test_held();
        int redirs;
        apply_reset();
        redirs = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 4'd6, 32'h2000, 16'hFFFE, 26'd0, 32'd0, 32'd9, 1'b1, 1'b0, 1'b1);
            #4;
            if (redirect === 1'b1) redirs++;
            if (c == 0) begin
                n_tests++; if (target !== 32'h1FFC) begin n_fail++; $display("FAIL held_target got=%h exp=00001ffc", target); end
            end else begin
                n_tests++; if (redirect !== 1'b0 || stall_id !== 1'b0) begin n_fail++; $display("FAIL held_cycle%0d redirect=%0b stall=%0b exp=0/0", c, redirect, stall_id); end
            end
            tick();
        end
        drive(1'b0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (redirs != 1) begin n_fail++; $display("FAIL held_redirs got=%0d exp=1", redirs); end
        n_tests++; if (br_cnt !== 16'd1) begin n_fail++; $display("FAIL held_brcnt got=%0d exp=1", br_cnt); end
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(1'b1, 4'd5, 32'h0, 16'hFFFF, 26'd0, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0);
        #4;
        n_tests++; if (redirect !== 1'b1 || target !== 32'h0) begin n_fail++; $display("FAIL bltz_wrap redirect=%0b target=%h exp=1/00000000", redirect, target); end
        tick();
        drive(1'b1, 4'd4, 32'h40, 16'h0001, 26'd0, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0);
        #4;
        n_tests++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL bgtz_neg redirect=%0b exp=0", redirect); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (br_cnt !== 16'd2 || taken_cnt !== 16'd1) begin n_fail++; $display("FAIL wrap_cnt got=%0d/%0d exp=2/1", br_cnt, taken_cnt); end
        tick();
    endtask

    task automatic test_jal_timeout();
        apply_reset();
        drive(1'b1, 4'd8, 32'h3000_0010, 16'd0, 26'h0000100, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #4;
        n_tests++; if (redirect !== 1'b1 || target !== 32'h3000_0400) begin n_fail++; $display("FAIL jal_target redirect=%0b target=%h exp=1/30000400", redirect, target); end
        n_tests++; if (link !== 1'b1 || link_addr !== 32'h3000_0018) begin n_fail++; $display("FAIL jal_link link=%0b addr=%h exp=1/30000018", link, link_addr); end
        tick();
        for (int c = 1; c <= 8; c++) begin
            drive(1'b1, 4'd9, 32'h500, 16'd0, 26'd0, 32'h4440, 32'd0, 1'b0, 1'b1, 1'b0);
            #4;
            n_tests++; if (stall_id !== 1'b1 || timeout_err !== 1'b0 || link !== 1'b0) begin n_fail++; $display("FAIL jr_wait%0d stall=%0b err=%0b link=%0b exp=1/0/0", c, stall_id, timeout_err, link); end
            tick();
        end
        drive(1'b1, 4'd9, 32'h500, 16'd0, 26'd0, 32'h4440, 32'd0, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL jr_timeout got=%0b exp=1", timeout_err); end
        n_tests++; if (redirect !== 1'b1 || target !== 32'h4440) begin n_fail++; $display("FAIL jr_target redirect=%0b target=%h exp=1/00004440", redirect, target); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        #4;
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%0b exp=1", timeout_err); end
        tick();
    endtask

    task automatic test_flush_reset();
        apply_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 4'd2, 32'h100, 16'd3, 26'd0, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 4'd2, 32'h100, 16'd3, 26'd0, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (redirect !== 1'b0 || stall_id !== 1'b0) begin n_fail++; $display("FAIL flush redirect=%0b stall=%0b exp=0/0", redirect, stall_id); end
        tick();
        drive(1'b0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (br_cnt !== 16'd0 || taken_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnt got=%0d/%0d exp=0/0", br_cnt, taken_cnt); end
        tick();
        drive(1'b1, 4'd1, 32'h200, 16'd1, 26'd0, 32'd7, 32'd7, 1'b1, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        #4;
        n_tests++; if (redirect !== 1'b0 || stall_id !== 1'b0) begin n_fail++; $display("FAIL held_reset redirect=%0b stall=%0b exp=0/0", redirect, stall_id); end
        tick();
        reset = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (redirect !== 1'b0 || br_cnt !== 16'd0) begin n_fail++; $display("FAIL post_reset redirect=%0b br_cnt=%0d exp=0/0", redirect, br_cnt); end
        tick();
        drive(1'b1, 4'd1, 32'h200, 16'd1, 26'd0, 32'd7, 32'd7, 1'b1, 1'b1, 1'b0);
        #4;
        n_tests++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset redirect=%0b exp=1", redirect); end
        tick();
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] pc, rs, rt;
        logic [15:0] imm;
        logic [25:0] idx;
        logic        nrs, nrt, rsr, rtr, etk;
        int          w, h;
        int          m_br, m_tk;
        apply_reset();
        m_br = 0;
        m_tk = 0;
        for (int n = 0; n < 80; n++) begin
            op  = 4'($urandom_range(0, 12));
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = 16'($urandom);
            idx = 26'($urandom);
            case ($urandom_range(0, 3))
                0:       rs = 32'd0;
                1:       rs = 32'h8000_0000;
                default: rs = $urandom;
            endcase
            rt  = ($urandom_range(0, 1) == 1) ? rs : $urandom;
            nrs = m_needs_rs(op);
            nrt = m_needs_rt(op);
            if (!m_is_ctrl(op)) begin
                drive(1'($urandom_range(0, 1)), op, pc, imm, idx, rs, rt,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                #4;
                n_tests++; if (stall_id !== 1'b0 || redirect !== 1'b0 || link !== 1'b0) begin n_fail++; $display("FAIL rnd_none op=%0d stall=%0b redirect=%0b link=%0b exp=0/0/0", op, stall_id, redirect, link); end
                tick();
                continue;
            end
            w = (nrs || nrt) ? $urandom_range(0, 3) : 0;
            h = $urandom_range(0, 2);
            for (int c = 0; c < w; c++) begin
                if (nrs && nrt) begin
                    rsr = 1'($urandom_range(0, 1));
                    rtr = rsr ? 1'b0 : 1'($urandom_range(0, 1));
                end else begin
                    rsr = 1'b0;
                    rtr = 1'($urandom_range(0, 1));
                end
                drive(1'b1, op, pc, imm, idx, rs, rt, rsr, rtr, 1'($urandom_range(0, 1)));
                #4;
                n_tests++; if (stall_id !== 1'b1 || redirect !== 1'b0) begin n_fail++; $display("FAIL rnd_wait op=%0d stall=%0b redirect=%0b exp=1/0", op, stall_id, redirect); end
                tick();
            end
            etk = m_taken(op, rs, rt);
            drive(1'b1, op, pc, imm, idx, rs, rt, 1'b1, 1'b1, (h > 0));
            #4;
            n_tests++; if (stall_id !== 1'b0 || redirect !== etk) begin n_fail++; $display("FAIL rnd_resolve op=%0d rs=%h rt=%h redirect=%0b exp=%0b stall=%0b", op, rs, rt, redirect, etk, stall_id); end
            n_tests++; if (link !== (op == 4'd8 || op == 4'd10)) begin n_fail++; $display("FAIL rnd_link op=%0d got=%0b", op, link); end
            if (etk) begin
                n_tests++; if (target !== m_target(op, pc, imm, idx, rs)) begin n_fail++; $display("FAIL rnd_target op=%0d got=%h exp=%h", op, target, m_target(op, pc, imm, idx, rs)); end
            end
            m_br++;
            if (etk) m_tk++;
            tick();
            for (int k = 1; k <= h; k++) begin
                drive(1'b1, op, pc, imm, idx, rs, rt, 1'b1, 1'b1, (k < h));
                #4;
                n_tests++; if (redirect !== 1'b0 || stall_id !== 1'b0 || link !== 1'b0) begin n_fail++; $display("FAIL rnd_held op=%0d redirect=%0b stall=%0b link=%0b exp=0/0/0", op, redirect, stall_id, link); end
                tick();
            end
            n_tests++; if (br_cnt !== 16'(m_br) || taken_cnt !== 16'(m_tk)) begin n_fail++; $display("FAIL rnd_cnt got=%0d/%0d exp=%0d/%0d", br_cnt, taken_cnt, m_br, m_tk); end
            n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rnd_err got=%0b exp=0", timeout_err); end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        test_reset();
        test_beq();
        test_bne_wait();
        test_held();
        test_wrap();
        test_jal_timeout();
        test_flush_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
